hazard_fwd_ctrl: RTL and testbench

- Pipeline hazard controller for the in-order RV32I core. Sits beside the decode stage.
- Tracks in-flight destination registers through EX/MEM/WB in an internal scoreboard shift register.
- Drives decode's forwarding mux selects (sel_ra1/sel_ra2), inserts load-use bubbles, and sequences branch-redirect flushes.
- Freezes tracking on data-memory back-pressure.

---
 rtl/hazard_fwd_ctrl.sv | 105 ++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: RV32I decode-side forwarding selects, load-use bubbles and redirect flushes.
// Optional perf counters stall_cnt/flush_cnt are built when HAZ_PERF_CNT_EN is defined.
module hazard_fwd_ctrl #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_ra1,
    input  logic [REG_AW-1:0] id_ra2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] id_wa,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    input  logic              mem_stall,
    output logic [1:0]        sel_ra1,
    output logic [1:0]        sel_ra2,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              flush_id,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);
    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] wa;
        logic              we;
    } ent_t;
    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

    ent_t       ex_e, mem_e, wb_e;
    logic       ex_ld;
    state_t     state;
    logic [1:0] cnt;
    logic       load_use, flushing, stall, issue;

    function automatic logic hit(input ent_t e, input logic [REG_AW-1:0] src);
        return e.vld && e.we && e.wa == src && src != '0;
    endfunction

    // only the EX entry can still be a load whose data is not yet available
    assign load_use = id_valid && ex_ld &&
                      ((id_use1 && hit(ex_e, id_ra1)) || (id_use2 && hit(ex_e, id_ra2)));
    assign flushing = !mem_stall && (ex_redirect || state == FLUSH);
    assign stall    = !mem_stall && load_use && !flushing;
    assign issue    = id_valid && !load_use && !flushing;

    always_comb begin
        sel_ra1   = !id_use1 ? 2'd0 : hit(ex_e, id_ra1) ? 2'd1 : hit(mem_e, id_ra1) ? 2'd2 :
                    hit(wb_e, id_ra1) ? 2'd3 : 2'd0;
        sel_ra2   = !id_use2 ? 2'd0 : hit(ex_e, id_ra2) ? 2'd1 : hit(mem_e, id_ra2) ? 2'd2 :
                    hit(wb_e, id_ra2) ? 2'd3 : 2'd0;
        stall_if  = mem_stall || stall;
        stall_id  = mem_stall || stall;
        bubble_ex = flushing || stall;
        flush_id  = flushing;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_e  <= '0;
            mem_e <= '0;
            wb_e  <= '0;
            ex_ld <= 1'b0;
            state <= RUN;
            cnt   <= '0;
        end else if (!mem_stall) begin
            wb_e  <= mem_e;
            mem_e <= ex_e;
            ex_e  <= issue ? {1'b1, id_wa, id_we} : '0;
            ex_ld <= issue && id_is_load;
            if (ex_redirect) begin
                state <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                cnt   <= CNT_INIT;
            end else if (state == FLUSH) begin
                if (cnt <= 2'd1) state <= RUN;
                cnt <= cnt - 2'd1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall) stall_q <= stall_q + 32'd1;
            if (!mem_stall && ex_redirect) flush_q <= flush_q + 32'd1;
        end
    end
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed vectors for hazard_fwd_ctrl with FLUSH_CYCLES=2.
module tb_hazard_fwd_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0, id_use1 = 1'b0, id_use2 = 1'b0, id_we = 1'b0, id_is_load = 1'b0;
    logic [4:0]  id_ra1 = '0, id_ra2 = '0, id_wa = '0;
    logic        ex_redirect = 1'b0, mem_stall = 1'b0;
    logic [1:0]  sel_ra1, sel_ra2;
    logic        stall_if, stall_id, bubble_ex, flush_id;
    logic [31:0] stall_cnt, flush_cnt;
    int          total = 0, bad = 0;
    logic [31:0] exp_one;

    hazard_fwd_ctrl #(.REG_AW(5), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
        .id_use1(id_use1), .id_use2(id_use2), .id_wa(id_wa), .id_we(id_we),
        .id_is_load(id_is_load), .ex_redirect(ex_redirect), .mem_stall(mem_stall),
        .sel_ra1(sel_ra1), .sel_ra2(sel_ra2), .stall_if(stall_if), .stall_id(stall_id),
        .bubble_ex(bubble_ex), .flush_id(flush_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic id(input logic v, input logic [4:0] ra1, input logic u1, input logic [4:0] ra2,
                      input logic u2, input logic [4:0] wa, input logic we, input logic ld);
        id_valid = v; id_ra1 = ra1; id_use1 = u1; id_ra2 = ra2; id_use2 = u2;
        id_wa = wa; id_we = we; id_is_load = ld;
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic si, input logic sd, input logic b, input logic f);
        chk({tag, ".stall_if"}, 32'(stall_if), 32'(si));
        chk({tag, ".stall_id"}, 32'(stall_id), 32'(sd));
        chk({tag, ".bubble_ex"}, 32'(bubble_ex), 32'(b));
        chk({tag, ".flush_id"}, 32'(flush_id), 32'(f));
    endtask

    initial begin
`ifdef HAZ_PERF_CNT_EN
        exp_one = 32'd1;
`else
        exp_one = 32'd0;
`endif
        #2;
        chk("rst.sel1", 32'(sel_ra1), 0);
        chk("rst.sel2", 32'(sel_ra2), 0);
        chk_ctl("rst", 0, 0, 0, 0);
        chk("rst.scnt", stall_cnt, 0);
        chk("rst.fcnt", flush_cnt, 0);
        cyc(); cyc();
        rst_n = 1'b1;

        // ADD x5 followed by readers of x5 walking down the pipe
        id(1, 0, 0, 0, 0, 5, 1, 0);
        cyc(); id(1, 5, 1, 0, 0, 0, 0, 0);
        chk("fwd.ex", 32'(sel_ra1), 1);
        chk_ctl("fwd.ex", 0, 0, 0, 0);
        cyc(); id(1, 5, 1, 0, 0, 0, 0, 0);
        chk("fwd.mem", 32'(sel_ra1), 2);
        cyc(); id(1, 5, 1, 0, 0, 0, 0, 0);
        chk("fwd.wb", 32'(sel_ra1), 3);
        cyc(); id(1, 5, 1, 0, 0, 0, 0, 0);
        chk("fwd.none", 32'(sel_ra1), 0);
        cyc(); id(1, 5, 0, 5, 0, 0, 0, 0);
        chk("fwd.unused", 32'(sel_ra1), 0);

        // LW x7 then ADD rs2=x7: one bubble, then forward from MEM
        cyc(); id(1, 0, 0, 0, 0, 7, 1, 1);
        cyc(); id(1, 0, 0, 7, 1, 8, 1, 0);
        chk_ctl("lu.stall", 1, 1, 1, 0);
        cyc();
        chk("lu.sel2", 32'(sel_ra2), 2);
        chk_ctl("lu.resume", 0, 0, 0, 0);
        cyc(); id(1, 8, 1, 0, 0, 0, 0, 0);
        chk("lu.issued", 32'(sel_ra1), 1);
        chk("lu.scnt", stall_cnt, exp_one);

        // x0 is never forwarded, even from a load
        cyc(); id(1, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(); id(1, 0, 1, 0, 1, 0, 1, 1);
            chk("x0.sel1", 32'(sel_ra1), 0);
            chk("x0.sel2", 32'(sel_ra2), 0);
            chk("x0.stall", 32'(stall_id), 0);
        end
        cyc(); id(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(); cyc(); cyc();

        // redirect coincident with load-use: flush only, held two cycles
        id(1, 0, 0, 0, 0, 9, 1, 1);
        cyc(); id(1, 9, 1, 0, 0, 0, 0, 0);
        chk_ctl("lu.pre", 1, 1, 1, 0);
        ex_redirect = 1'b1; #1;
        chk_ctl("rd.c0", 0, 0, 1, 1);
        cyc(); ex_redirect = 1'b0; #1;
        chk_ctl("rd.c1", 0, 0, 1, 1);
        cyc();
        chk_ctl("rd.run", 0, 0, 0, 0);
        chk("rd.sel1", 32'(sel_ra1), 3);
        chk("rd.fcnt", flush_cnt, exp_one);
        chk("rd.scnt", stall_cnt, exp_one);
        cyc(); id(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(); cyc(); cyc();

        // mem_stall freezes the scoreboard and ignores redirects
        id(1, 0, 0, 0, 0, 10, 1, 0);
        cyc(); id(1, 10, 1, 0, 0, 0, 0, 0);
        mem_stall = 1'b1; ex_redirect = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            chk("ms.sel1", 32'(sel_ra1), 1);
            chk_ctl("ms", 1, 1, 0, 0);
            cyc();
        end
        mem_stall = 1'b0; ex_redirect = 1'b0; #1;
        chk("ms.rel.sel1", 32'(sel_ra1), 1);
        chk_ctl("ms.rel", 0, 0, 0, 0);
        cyc();
        chk("ms.shift", 32'(sel_ra1), 2);
        chk("ms.fcnt", flush_cnt, exp_one);

        // async reset in the middle of a flush
        id(1, 0, 0, 0, 0, 11, 1, 0);
        cyc(); id(1, 0, 0, 0, 0, 12, 1, 0);
        cyc(); id(1, 0, 0, 0, 0, 13, 1, 0);
        cyc(); id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_redirect = 1'b1;
        cyc(); ex_redirect = 1'b0; id(1, 13, 1, 12, 1, 0, 0, 0);
        chk("ar.pre.sel1", 32'(sel_ra1), 2);
        chk("ar.pre.sel2", 32'(sel_ra2), 3);
        chk("ar.pre.flush", 32'(flush_id), 1);
        #2 rst_n = 1'b0; #1;
        chk("ar.sel1", 32'(sel_ra1), 0);
        chk("ar.sel2", 32'(sel_ra2), 0);
        chk_ctl("ar", 0, 0, 0, 0);
        chk("ar.scnt", stall_cnt, 0);
        chk("ar.fcnt", flush_cnt, 0);
        cyc(); rst_n = 1'b1; #1;
        chk("ar.post.sel1", 32'(sel_ra1), 0);
        cyc();
        chk_ctl("ar.post", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
